// File: rtl/ram_pkg.sv
// Shared definitions for the RAM BIST controller and the Sync_RAM bench:
// default geometry, background pattern and controller state encoding.
package ram_pkg;

  localparam int unsigned   DEF_ADDR_W  = 4;
  localparam int unsigned   DEF_DATA_W  = 8;
  localparam logic [7:0]    DEF_PATTERN = 8'hAA;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_BG,
    S_RD0,
    S_CHK0,
    S_RD1,
    S_CHK1,
    S_FIN
  } bist_state_e;

endpackage

// File: rtl/ram_bist_if.sv
// Single-port synchronous RAM bus: one access per cycle, registered read data.
interface ram_bist_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (output we, output addr, output din, input  dout);
  modport slave  (input  we, input  addr, input  din, output dout);
endinterface

// File: rtl/ram_bist.sv
// March-style RAM self test: write background P ascending, read P / write ~P
// ascending, then read ~P descending; first mismatch is latched.
module ram_bist
  import ram_pkg::*;
#(
  parameter int unsigned        ADDR_W  = DEF_ADDR_W,
  parameter int unsigned        DATA_W  = DEF_DATA_W,
  parameter logic [DATA_W-1:0]  PATTERN = DATA_W'(DEF_PATTERN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  ram_bist_if.master        ram
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  bist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic              we_c;
  logic [DATA_W-1:0] din_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    we_c        = 1'b0;
    din_c       = '0;

    unique case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          state_d     = S_WR_BG;
          addr_d      = '0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
        end
      end
      S_WR_BG: begin
        we_c  = 1'b1;
        din_c = PATTERN;
        if (addr_q == ADDR_MAX) begin
          state_d = S_RD0;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_RD0: state_d = S_CHK0;
      S_CHK0: begin
        if (ram.dout == PATTERN) begin
          we_c  = 1'b1;
          din_c = ~PATTERN;
          // Terminal count hands over to the descending pass at the same address.
          if (addr_q == ADDR_MAX) begin
            state_d = S_RD1;
          end else begin
            state_d = S_RD0;
            addr_d  = addr_q + 1'b1;
          end
        end else begin
          state_d     = S_FIN;
          pass_d      = 1'b0;
          fail_addr_d = addr_q;
          fail_data_d = ram.dout;
        end
      end
      S_RD1: state_d = S_CHK1;
      S_CHK1: begin
        if (ram.dout == ~PATTERN) begin
          if (addr_q == '0) begin
            state_d = S_FIN;
            pass_d  = 1'b1;
          end else begin
            state_d = S_RD1;
            addr_d  = addr_q - 1'b1;
          end
        end else begin
          state_d     = S_FIN;
          pass_d      = 1'b0;
          fail_addr_d = addr_q;
          fail_data_d = ram.dout;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_WR_BG) || (state_q == S_RD0) || (state_q == S_CHK0) ||
                     (state_q == S_RD1)   || (state_q == S_CHK1);
  assign done      = (state_q == S_FIN);
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign ram.we    = we_c;
  assign ram.addr  = addr_q;
  assign ram.din   = din_c;

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist driving a fault-injectable Sync_RAM model; expected bus
// traces and results come from an array-based March reference.
module tb_ram_bist;
  import ram_pkg::*;

  localparam int unsigned AW    = DEF_ADDR_W;
  localparam int unsigned DW    = DEF_DATA_W;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [DW-1:0] PAT = DEF_PATTERN;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } op_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;

  int vectors = 0;
  int miscompares = 0;

  // Fault controls for the RAM model
  logic          stuck_en = 1'b0;
  logic [AW-1:0] stuck_addr = '0;
  int unsigned   stuck_bit = 0;
  logic          stuck_val = 1'b0;
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic [DW-1:0] corrupt_val = '0;

  op_t           exp_q[$];
  logic          exp_pass;
  logic [AW-1:0] exp_faddr;
  logic [DW-1:0] exp_fdata;

  logic [DW-1:0] mem [DEPTH];

  ram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_bist #(.ADDR_W(AW), .DATA_W(DW), .PATTERN(PAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .ram       (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fault_read(input logic [AW-1:0] a, input logic [DW-1:0] v);
    logic [DW-1:0] m;
    m = DW'(1) << stuck_bit;
    if (stuck_en && a == stuck_addr) return stuck_val ? (v | m) : (v & ~m);
    return v;
  endfunction

  function automatic logic [DW-1:0] fault_write(input logic [AW-1:0] a, input logic [DW-1:0] v);
    if (corrupt_en && a == corrupt_addr && v == ~PAT) return corrupt_val;
    return v;
  endfunction

  // Sync_RAM: one access per cycle, read-first registered output
  always_ff @(posedge clk) begin
    if (bus.we) mem[bus.addr] <= fault_write(bus.addr, bus.din);
    bus.dout <= fault_read(bus.addr, mem[bus.addr]);
  end

  function automatic void push_op(input logic we, input int unsigned a, input logic [DW-1:0] d);
    op_t o;
    o.we = we; o.addr = AW'(a); o.din = d;
    exp_q.push_back(o);
  endfunction

  // Reference March run: one queue entry per busy cycle
  function automatic void build_expected();
    logic [DW-1:0] mm [DEPTH];
    logic [DW-1:0] r;
    exp_q.delete();
    exp_pass = 1'b0; exp_faddr = '0; exp_fdata = '0;
    for (int unsigned a = 0; a < DEPTH; a++) begin
      push_op(1'b1, a, PAT);
      mm[a] = fault_write(AW'(a), PAT);
    end
    for (int unsigned a = 0; a < DEPTH; a++) begin
      push_op(1'b0, a, '0);
      r = fault_read(AW'(a), mm[a]);
      if (r != PAT) begin
        push_op(1'b0, a, '0);
        exp_faddr = AW'(a); exp_fdata = r;
        return;
      end
      push_op(1'b1, a, ~PAT);
      mm[a] = fault_write(AW'(a), ~PAT);
    end
    for (int a = int'(DEPTH) - 1; a >= 0; a--) begin
      push_op(1'b0, a, '0);
      r = fault_read(AW'(a), mm[a]);
      push_op(1'b0, a, '0);
      if (r != ~PAT) begin
        exp_faddr = AW'(a); exp_fdata = r;
        return;
      end
    end
    exp_pass = 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_faults();
    stuck_en = 1'b0;
    corrupt_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".busy"},      32'(busy),      32'd0);
    chk({tag, ".done"},      32'(done),      32'd0);
    chk({tag, ".pass"},      32'(pass),      32'd0);
    chk({tag, ".fail_addr"}, 32'(fail_addr), 32'd0);
    chk({tag, ".fail_data"}, 32'(fail_data), 32'd0);
    chk({tag, ".ram_we"},    32'(bus.we),    32'd0);
    chk({tag, ".ram_addr"},  32'(bus.addr),  32'd0);
    chk({tag, ".ram_din"},   32'(bus.din),   32'd0);
  endtask

  // restart_at / rst_at: busy-cycle index (0-based) at which to pulse start / rst
  task automatic run_test(input string tag, input int restart_at, input int rst_at);
    int n;
    build_expected();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      chk({tag, ".done_low"}, 32'(done), 32'd0);
      if (n < exp_q.size()) begin
        chk($sformatf("%s.we[%0d]", tag, n),   32'(bus.we),   32'(exp_q[n].we));
        chk($sformatf("%s.addr[%0d]", tag, n), 32'(bus.addr), 32'(exp_q[n].addr));
        if (exp_q[n].we) chk($sformatf("%s.din[%0d]", tag, n), 32'(bus.din), 32'(exp_q[n].din));
      end
      if (n == restart_at) start = 1'b1;
      if (n == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs({tag, ".rst"});
        return;
      end
      step();
      start = 1'b0;
      n++;
    end
    chk({tag, ".busy_cycles"}, 32'(n), 32'(exp_q.size()));
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    chk({tag, ".ram_we_fin"}, 32'(bus.we), 32'd0);
    chk({tag, ".pass"}, 32'(pass), 32'(exp_pass));
    if (!exp_pass) begin
      chk({tag, ".fail_addr"}, 32'(fail_addr), 32'(exp_faddr));
      chk({tag, ".fail_data"}, 32'(fail_data), 32'(exp_fdata));
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_reset_outputs("reset");
    start = 1'b0;
    rst = 1'b0;
    step();
    check_reset_outputs("idle");

    // Fault-free run: 80 busy cycles, pass, word 5 holds ~P
    clear_faults();
    run_test("clean", -1, -1);
    chk("clean.len80", 32'(exp_q.size()), 32'd80);
    chk("clean.word5", 32'(mem[5]), 32'h55);

    // Stuck-at-1 on bit 0 of word 3: caught in the ascending pass
    stuck_en = 1'b1; stuck_addr = 4'h3; stuck_bit = 0; stuck_val = 1'b1;
    run_test("stuck3", -1, -1);
    chk("stuck3.fa", 32'(fail_addr), 32'h3);
    chk("stuck3.fd", 32'(fail_data), 32'hAB);
    clear_faults();

    // Word C loses its ~P write: caught in the descending pass
    corrupt_en = 1'b1; corrupt_addr = 4'hC; corrupt_val = 8'h00;
    run_test("corruptC", -1, -1);
    chk("corruptC.fa", 32'(fail_addr), 32'hC);
    chk("corruptC.fd", 32'(fail_data), 32'h00);
    clear_faults();

    // Start during a run is ignored
    run_test("restart20", 19, -1);
    chk("restart20.pass", 32'(pass), 32'd1);

    // Reset mid-run then a fresh full run
    run_test("rst40", -1, 39);
    step();
    check_reset_outputs("rst40.idle");
    run_test("after_rst", -1, -1);

    // Randomized fault scenarios
    for (int i = 0; i < 8; i++) begin
      stuck_en     = 1'($urandom_range(0, 1));
      stuck_addr   = AW'($urandom_range(0, DEPTH - 1));
      stuck_bit    = $urandom_range(0, DW - 1);
      stuck_val    = 1'($urandom_range(0, 1));
      corrupt_en   = 1'($urandom_range(0, 1));
      corrupt_addr = AW'($urandom_range(0, DEPTH - 1));
      corrupt_val  = DW'($urandom);
      run_test($sformatf("rand%0d", i), -1, -1);
    end
    clear_faults();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
